// File: rtl/store_narrower.sv
// store_narrower: splits byte/halfword/word stores onto a 16-bit memory port.
// Byte and halfword stores take one beat. Word stores take two beats, low half first.
// Misaligned requests and the reserved size issue no beat. They raise a one-cycle err pulse instead.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and ready are both 1.
// Once valid is raised, the producer holds valid and its payload stable until that transfer.
// The ready side may change at any time. It never depends on valid in the same cycle.
module store_narrower (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] in_addr,
    input  logic [1:0]  in_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic        err_q;
    logic        accept;
    logic        misaligned;

    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    // Classify the incoming request; reserved size counts as misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = in_addr[0];
            SIZE_WORD: misaligned = (in_addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    end

    // Next-state logic: a valid accept starts a burst; each completed beat advances it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    state_d = (size_q == SIZE_WORD) ? BEAT1 : IDLE;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request on accept, and flag rejection for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && misaligned;
            if (accept) begin
                addr_q <= in_addr;
                data_q <= in_data;
                size_q <= in_size;
            end
        end
    end

    // Output decode from state and the captured request; the beat fields are zero when no beat is presented.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        busy      = (state_q != IDLE);
        err       = err_q && !rst;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (state_q)
            BEAT0: begin
                mem_valid = 1'b1;
                if (size_q == SIZE_BYTE) begin
                    mem_addr  = {addr_q[31:1], 1'b0};
                    mem_wdata = {data_q[7:0], data_q[7:0]};
                    mem_be    = addr_q[0] ? 2'b10 : 2'b01;
                end else begin
                    mem_addr  = addr_q;
                    mem_wdata = data_q[15:0];
                    mem_be    = 2'b11;
                end
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = addr_q + 32'd2;
                mem_wdata = data_q[31:16];
                mem_be    = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
